// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int FQ_DEPTH = 2;
    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 32;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fq_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ADDR_W'(32'hFFFF_FFFC);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {instr, pc} entries with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int W     = INSTR_W + ADDR_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    input  logic         flush,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         full
);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_enq_s;
    logic             do_deq_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Qualify requests against occupancy so pointers never overrun.
    always_comb begin
        do_enq_s = enq && (count_r != CNT_W'(DEPTH));
        do_deq_s = deq && (count_r != CNT_W'(0));
    end

    // Pointer and occupancy state; flush empties the queue in one edge.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_enq_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_deq_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_enq_s, do_deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed through count/pointers.
    always_ff @(posedge clock) begin
        if (do_enq_s) mem_r[wr_ptr_r] <= enq_data;
    end

    assign head_valid = (count_r != CNT_W'(0));
    assign head_data  = mem_r[rd_ptr_r];
    assign full       = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the external PC register, issues one memory
// request at a time and buffers returned words for decode.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_wen,
    output logic [ADDR_W-1:0]  next_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready
);

    fetch_state_e      state_r;
    fetch_state_e      state_nx_s;
    logic [ADDR_W-1:0] drain_addr_r;
    logic [ADDR_W-1:0] drain_addr_nx_s;
    logic              req_s;
    logic              accept_s;
    logic              enq_s;
    logic              deq_s;
    logic              q_valid_s;
    logic              full_s;
    fq_entry_t         enq_entry_s;
    fq_entry_t         head_s;

    // Request generation; DRAIN keeps the abandoned address on the bus until acked.
    always_comb begin
        req_s     = 1'b0;
        imem_addr = pc;
        case (state_r)
            FETCH: begin
                req_s     = !full_s;
                imem_addr = pc;
            end
            DRAIN: begin
                req_s     = 1'b1;
                imem_addr = drain_addr_r;
            end
            default: begin
                req_s     = 1'b0;
                imem_addr = pc;
            end
        endcase
    end

    assign imem_req = reset && req_s;
    assign accept_s = imem_req && imem_ack;

    // PC update, enqueue and next state; a redirect overrides sequential flow.
    always_comb begin
        pc_wen          = 1'b0;
        next_pc         = pc + 32'd4;
        enq_s           = 1'b0;
        state_nx_s      = state_r;
        drain_addr_nx_s = drain_addr_r;
        if (redirect_valid) begin
            pc_wen  = reset;
            next_pc = word_align(redirect_target);
            if ((state_r == FETCH) && imem_req && !imem_ack) begin
                state_nx_s      = DRAIN;
                drain_addr_nx_s = pc;
            end else if ((state_r == DRAIN) && accept_s) begin
                state_nx_s = FETCH;
            end else begin
                state_nx_s = state_r;
            end
        end else if (accept_s) begin
            if (state_r == FETCH) begin
                pc_wen = 1'b1;
                enq_s  = 1'b1;
            end else begin
                state_nx_s = FETCH;
            end
        end else begin
            pc_wen = 1'b0;
        end
    end

    // FSM and drain address registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= FETCH;
            drain_addr_r <= 32'h0000_0000;
        end else begin
            state_r      <= state_nx_s;
            drain_addr_r <= drain_addr_nx_s;
        end
    end

    assign enq_entry_s = '{instr: imem_rdata, pc: pc};
    assign deq_s       = if_valid && if_ready;

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .W     (INSTR_W + ADDR_W)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .enq        (enq_s),
        .enq_data   (enq_entry_s),
        .deq        (deq_s),
        .flush      (redirect_valid),
        .head_valid (q_valid_s),
        .head_data  (head_s),
        .full       (full_s)
    );

    assign if_valid = reset && q_valid_s;
    assign if_instr = head_s.instr;
    assign if_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table for the named fetch scenarios, then random traffic
// compared against a queue-based reference model of the fetch rules.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_wen;
    logic [31:0] next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .pc_wen          (pc_wen),
        .next_pc         (next_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wen;
        logic [31:0] e_next;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ifpc;
    } vec_t;

    vec_t tbl[$];

    // Reference model: fetched words in order, plus the discard-pending flag.
    logic [63:0] mq[$];
    bit          mdrain;
    logic [31:0] mdaddr;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I0 = 32'h1100_0013, I1 = 32'h2200_0013, I2 = 32'h3300_0013;
    localparam logic [31:0] B0 = 32'hB000_0001, B1 = 32'hB000_0002, JK = 32'hDEAD_BEEF;
    localparam logic [31:0] C0 = 32'hC000_0001, D0 = 32'hD000_0001, E0 = 32'hE000_0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic redir, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_wen, input logic [31:0] e_next,
                       input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_ifpc);
        vec_t v;
        v.rst = rst; v.redir = redir; v.tgt = tgt; v.ack = ack; v.rdata = rdata; v.ready = ready;
        v.e_req = e_req; v.e_addr = e_addr; v.e_wen = e_wen; v.e_next = e_next;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_ifpc = e_ifpc;
        tbl.push_back(v);
    endtask

    // One clock: drive, check at negedge, then advance model and PC register.
    task automatic run_cycle(input bit use_tbl, input vec_t v);
        logic        m_req, m_acc, m_wen, m_valid;
        logic [31:0] m_addr, m_next, m_instr, m_ifpc;
        logic        e_req, e_wen, e_valid;
        logic [31:0] e_addr, e_next, e_instr, e_ifpc;
        reset = v.rst; redirect_valid = v.redir; redirect_target = v.tgt;
        imem_ack = v.ack; imem_rdata = v.rdata; if_ready = v.ready;
        @(negedge clock);
        m_req   = reset && (mdrain || (mq.size() < 2));
        m_addr  = mdrain ? mdaddr : pc;
        m_acc   = m_req && imem_ack;
        m_wen   = reset && (redirect_valid || (m_acc && !mdrain));
        m_next  = redirect_valid ? (redirect_target & 32'hFFFF_FFFC) : pc + 32'd4;
        m_valid = reset && (mq.size() != 0);
        m_instr = m_valid ? mq[0][63:32] : 32'h0;
        m_ifpc  = m_valid ? mq[0][31:0] : 32'h0;
        e_req   = use_tbl ? v.e_req   : m_req;
        e_addr  = use_tbl ? v.e_addr  : m_addr;
        e_wen   = use_tbl ? v.e_wen   : m_wen;
        e_next  = use_tbl ? v.e_next  : m_next;
        e_valid = use_tbl ? v.e_valid : m_valid;
        e_instr = use_tbl ? v.e_instr : m_instr;
        e_ifpc  = use_tbl ? v.e_ifpc  : m_ifpc;
        chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        chk("pc_wen", {31'h0, pc_wen}, {31'h0, e_wen});
        chk("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        if (e_wen) chk("next_pc", next_pc, e_next);
        if (e_valid) begin
            chk("if_instr", if_instr, e_instr);
            chk("if_pc", if_pc, e_ifpc);
        end
        @(posedge clock);
        #1;
        if (!reset) begin
            mq.delete();
            mdrain = 1'b0;
            mdaddr = 32'h0;
        end else begin
            if (m_valid && if_ready) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                if (!mdrain && m_req && !imem_ack) begin
                    mdrain = 1'b1;
                    mdaddr = pc;
                end else if (mdrain && m_acc) begin
                    mdrain = 1'b0;
                end
            end else if (m_acc) begin
                if (mdrain) mdrain = 1'b0;
                else mq.push_back({imem_rdata, pc});
            end
        end
        if (m_wen) pc = m_next;
    endtask

    initial begin
        vec_t rv;
        reset = 1'b0; pc = 32'h0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
        mq.delete(); mdrain = 1'b0; mdaddr = 32'h0;
        repeat (2) @(posedge clock);
        #1;

        //  rst redir tgt            ack rdata ready | req addr          wen next          vld instr ifpc
        add(1, 0, 32'h0,          1, I0, 1,  1, 32'h0,        1, 32'h4,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, I1, 1,  1, 32'h4,        1, 32'h8,        1, I0, 32'h0);
        add(1, 0, 32'h0,          1, I2, 1,  1, 32'h8,        1, 32'hC,        1, I1, 32'h4);
        add(1, 0, 32'h0,          0, JK, 1,  1, 32'hC,        0, 32'h0,        1, I2, 32'h8);
        add(1, 1, 32'h0,          0, JK, 0,  1, 32'hC,        1, 32'h0,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, JK, 0,  1, 32'hC,        0, 32'h0,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, B0, 0,  1, 32'h0,        1, 32'h4,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, B1, 0,  1, 32'h4,        1, 32'h8,        1, B0, 32'h0);
        add(1, 0, 32'h0,          1, JK, 0,  0, 32'h0,        0, 32'h0,        1, B0, 32'h0);
        add(1, 0, 32'h0,          1, JK, 1,  0, 32'h0,        0, 32'h0,        1, B0, 32'h0);
        add(1, 1, 32'h40,         1, JK, 1,  1, 32'h8,        1, 32'h40,       1, B1, 32'h4);
        add(1, 1, 32'hB,          1, JK, 1,  1, 32'h40,       1, 32'h8,        0, 32'h0, 32'h0);
        add(1, 1, 32'h103,        0, JK, 1,  1, 32'h8,        1, 32'h100,      0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          0, JK, 1,  1, 32'h8,        0, 32'h0,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, JK, 1,  1, 32'h8,        0, 32'h0,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, C0, 0,  1, 32'h100,      1, 32'h104,      0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          0, JK, 1,  1, 32'h104,      0, 32'h0,        1, C0, 32'h100);
        add(1, 1, 32'hFFFF_FFFF,  1, JK, 1,  1, 32'h104,      1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, D0, 0,  1, 32'hFFFF_FFFC, 1, 32'h0,       0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          0, JK, 0,  1, 32'h0,        0, 32'h0,        1, D0, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,          0, JK, 0,  0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0);
        add(0, 0, 32'h0,          1, JK, 1,  0, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          0, JK, 1,  1, 32'h0,        0, 32'h0,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          1, E0, 1,  1, 32'h0,        1, 32'h4,        0, 32'h0, 32'h0);
        add(1, 0, 32'h0,          0, JK, 1,  1, 32'h4,        0, 32'h0,        1, E0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) run_cycle(1'b1, tbl[i]);

        for (int i = 0; i < 800; i++) begin
            rv.rst   = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            rv.redir = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            rv.tgt   = $urandom;
            rv.ack   = ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0;
            rv.rdata = $urandom;
            rv.ready = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
            rv.e_req = 1'b0; rv.e_addr = 32'h0; rv.e_wen = 1'b0; rv.e_next = 32'h0;
            rv.e_valid = 1'b0; rv.e_instr = 32'h0; rv.e_ifpc = 32'h0;
            run_cycle(1'b0, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
